// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes, write FSM states and helpers.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, HAVE_AW, HAVE_W, COMMIT, RESP} wr_state_e;

    function automatic int clog2(input int v);
        int r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// axi_lite_wr_ctrl: independent one-deep AW/W buffers, write FSM and B channel.
module axi_lite_wr_ctrl
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic                    err_i,
    output logic                    commit_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] strb_o
);
    wr_state_e state_q, state_d;
    logic aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic awready_q, wready_q, bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic aw_hs, w_hs, done;

    assign aw_hs = awvalid_i && awready_q;
    assign w_hs  = wvalid_i && wready_q;
    assign done  = bvalid_q && bready_i;

    // Buffers stay full through COMMIT and RESP so a stalled B channel blocks new AW/W.
    always_comb begin
        aw_full_d = (aw_full_q && !done) || aw_hs;
        w_full_d  = (w_full_q && !done) || w_hs;
        state_d   = state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (state_q)
            COMMIT: begin
                state_d  = RESP;
                bvalid_d = 1'b1;
                bresp_d  = err_i ? RESP_SLVERR : RESP_OKAY;
            end
            RESP: if (done) begin
                state_d  = IDLE;
                bvalid_d = 1'b0;
            end
            default: state_d = (aw_full_q && w_full_q) ? COMMIT :
                               (aw_full_d && w_full_d) ? state_q :
                               aw_full_d ? HAVE_AW : w_full_d ? HAVE_W : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            if (aw_hs) awaddr_q <= awaddr_i;
            if (w_hs) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign commit_o  = state_q == COMMIT;
    assign addr_o    = awaddr_q;
    assign data_o    = wdata_q;
    assign strb_o    = wstrb_q;
endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave register bank with read-only status registers
// and per-register write strobes.
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int                             ADDR_WIDTH = 32,
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                     s_axi_awprot,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                     s_axi_arprot,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_W    = NUM_REGS > 1 ? clog2(NUM_REGS) : 1;
    localparam int TOP_LSB  = ADDR_LSB + IDX_W;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_in [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic commit, wr_oor, wr_err, rd_oor, ar_hs;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb;
    logic [IDX_W-1:0] widx, ridx;
    logic rvalid_q, rvalid_d, arready_q;
    logic [1:0] rresp_q, rresp_d;
    logic unused_ok;

    axi_lite_wr_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr (
        .clk(s_axi_aclk), .rst(s_axi_areset),
        .awaddr_i(s_axi_awaddr), .awvalid_i(s_axi_awvalid), .awready_o(s_axi_awready),
        .wdata_i(s_axi_wdata), .wstrb_i(s_axi_wstrb), .wvalid_i(s_axi_wvalid), .wready_o(s_axi_wready),
        .bresp_o(s_axi_bresp), .bvalid_o(s_axi_bvalid), .bready_i(s_axi_bready),
        .err_i(wr_err), .commit_o(commit), .addr_o(waddr), .data_o(wdata), .strb_o(wstrb)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        assign regs_in[i] = regs_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign widx   = waddr[ADDR_LSB +: IDX_W];
    assign ridx   = s_axi_araddr[ADDR_LSB +: IDX_W];
    assign wr_oor = 32'(widx) >= NUM_REGS || (waddr >> TOP_LSB) != '0;
    assign rd_oor = 32'(ridx) >= NUM_REGS || (s_axi_araddr >> TOP_LSB) != '0;
    assign wr_err = wr_oor || RO_MASK[widx];
    assign ar_hs  = s_axi_arvalid && arready_q;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, waddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (commit && !wr_err) begin
            wr_pulse_d[widx] = 1'b1;
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) regs_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

    // Reads sample regs_q, so a read colliding with a commit returns the pre-write value.
    always_comb begin
        rvalid_d = ar_hs || (rvalid_q && !s_axi_rready);
        rdata_d  = !ar_hs ? rdata_q : rd_oor ? '0 : RO_MASK[ridx] ? regs_in[ridx] : regs_q[ridx];
        rresp_d  = !ar_hs ? rresp_q : rd_oor ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            arready_q  <= !rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign wr_pulse_o    = wr_pulse_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: directed AXI4-Lite transactions against hand-computed register images.
module tb_axi_lite_regbank;
    localparam logic [511:0] RST = {320'h0, 32'h55AA55AA, 32'h0, 32'h33333333, 32'h0, 32'h11223344, 32'h0};

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [2:0] awprot = 3'b101, arprot = 3'b010;
    logic [3:0] wstrb = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [511:0] regs_o, regs_i, exp_regs;
    logic [15:0] wr_pulse;
    int n_vec = 0, n_err = 0;
    logic [1:0] r;
    logic [15:0] p;
    logic [31:0] d;

    always #5 clk = ~clk;

    axi_lite_regbank #(.RO_MASK(16'h0008), .RST_VAL(RST)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_o(regs_o), .regs_i(regs_i), .wr_pulse_o(wr_pulse)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                      output logic [1:0] resp, output logic [15:0] pulse);
        logic aw_go, w_go;
        awaddr = a; wdata = dat; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_go = awready;
            w_go = wready;
            tick();
            if (aw_go) awvalid = 0;
            if (w_go) wvalid = 0;
        end
        for (int i = 0; i < 20 && !bvalid; i++) tick();
        chk("wr_bvalid", 512'(bvalid), 512'(1'b1));
        resp = bresp;
        pulse = wr_pulse;
        tick();
        bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
        araddr = a; arvalid = 1; rready = 1;
        for (int i = 0; i < 20 && !arready; i++) tick();
        tick();
        arvalid = 0;
        chk("rd_rvalid", 512'(rvalid), 512'(1'b1));
        dat = rdata;
        resp = rresp;
        tick();
        rready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        regs_i = {16{32'hA5A5A5A5}};
        regs_i[96 +: 32] = 32'hCAFE0001;
        exp_regs = RST;
        repeat (3) tick();
        chk("rst_awready", 512'(awready), 512'(1'b0));
        chk("rst_wready", 512'(wready), 512'(1'b0));
        chk("rst_arready", 512'(arready), 512'(1'b0));
        chk("rst_bvalid", 512'(bvalid), 512'(1'b0));
        chk("rst_rvalid", 512'(rvalid), 512'(1'b0));
        chk("rst_rdata", 512'(rdata), 512'(32'h0));
        chk("rst_regs", regs_o, exp_regs);
        rst = 0;
        chk("rel_awready_pre", 512'(awready), 512'(1'b0));
        tick();
        chk("rel_ready", 512'({awready, wready, arready}), 512'(3'b111));

        // same-cycle AW/W, then bready held low
        awaddr = 32'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("b_edge1", 512'(bvalid), 512'(1'b0));
        tick();
        chk("b_edge2", 512'(bvalid), 512'(1'b0));
        tick();
        exp_regs[64 +: 32] = 32'hDEADBEEF;
        chk("b_edge3", 512'({bvalid, bresp}), 512'(3'b100));
        chk("w_same_regs", regs_o, exp_regs);
        chk("w_same_pulse", 512'(wr_pulse), 512'(16'h0004));
        awaddr = 32'h10; awvalid = 1;
        repeat (2) tick();
        chk("hold_b", 512'({bvalid, bresp}), 512'(3'b100));
        chk("hold_awready", 512'(awready), 512'(1'b0));
        chk("hold_pulse", 512'(wr_pulse), 512'(16'h0));
        awvalid = 0; bready = 1;
        tick();
        chk("b_done", 512'(bvalid), 512'(1'b0));
        bready = 0;

        // W first, AW three edges later, partial strobe
        wdata = 32'h0000AA00; wstrb = 4'h2; wvalid = 1;
        tick();
        wvalid = 0;
        chk("w_only_wready", 512'(wready), 512'(1'b0));
        repeat (2) tick();
        awaddr = 32'h04; awvalid = 1;
        tick();
        awvalid = 0;
        chk("late_aw_b", 512'(bvalid), 512'(1'b0));
        repeat (2) tick();
        exp_regs[32 +: 32] = 32'h1122AA44;
        chk("late_aw_resp", 512'({bvalid, bresp}), 512'(3'b100));
        chk("late_aw_regs", regs_o, exp_regs);
        chk("late_aw_pulse", 512'(wr_pulse), 512'(16'h0002));
        bready = 1;
        tick();
        bready = 0;

        wr(32'h40, 32'h12345678, 4'hF, r, p);
        chk("oor_wr_resp", 512'(r), 512'(2'b10));
        chk("oor_wr_pulse", 512'(p), 512'(16'h0));
        chk("oor_wr_regs", regs_o, exp_regs);
        rd(32'h40, d, r);
        chk("oor_rd", 512'({d, r}), 512'({32'h0, 2'b10}));
        rd(32'h1000_0008, d, r);
        chk("oor_hi_rd", 512'({d, r}), 512'({32'h0, 2'b10}));

        wr(32'h10, 32'hFFFFFFFF, 4'h0, r, p);
        chk("strb0_resp", 512'(r), 512'(2'b00));
        chk("strb0_pulse", 512'(p), 512'(16'h0010));
        chk("strb0_regs", regs_o, exp_regs);

        wr(32'h0C, 32'h12345678, 4'hF, r, p);
        chk("ro_wr_resp", 512'(r), 512'(2'b10));
        chk("ro_wr_pulse", 512'(p), 512'(16'h0));
        chk("ro_wr_regs", regs_o, exp_regs);
        rd(32'h0C, d, r);
        chk("ro_rd", 512'({d, r}), 512'({32'hCAFE0001, 2'b00}));
        rd(32'h14, d, r);
        chk("rw_rd_rst", 512'({d, r}), 512'({32'h55AA55AA, 2'b00}));
        rd(32'h0A, d, r);
        chk("rd_low_bits", 512'({d, r}), 512'({32'hDEADBEEF, 2'b00}));

        // read lands on the commit edge of a write to the same register
        awaddr = 32'h0; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        araddr = 32'h0; arvalid = 1;
        tick();
        arvalid = 0;
        exp_regs[0 +: 32] = 32'h12345678;
        chk("coll_rvalid", 512'({rvalid, bvalid}), 512'(2'b11));
        chk("coll_rdata", 512'(rdata), 512'(32'h0));
        chk("coll_regs", regs_o, exp_regs);
        bready = 1; rready = 1;
        tick();
        chk("coll_done", 512'({rvalid, bvalid}), 512'(2'b00));
        bready = 0; rready = 0;

        // rready backpressure
        araddr = 32'h08; arvalid = 1;
        tick();
        araddr = 32'h04;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_r", 512'({rvalid, rresp, rdata}), 512'({1'b1, 2'b00, 32'hDEADBEEF}));
            chk("bp_arready", 512'(arready), 512'(1'b0));
        end
        rready = 1;
        tick();
        chk("bp_release", 512'({rvalid, arready}), 512'(2'b01));
        tick();
        arvalid = 0;
        chk("bp_second", 512'({rvalid, rresp, rdata}), 512'({1'b1, 2'b00, 32'h1122AA44}));
        tick();
        rready = 0;

        // reset between AW and W acceptance
        awaddr = 32'h14; awvalid = 1;
        tick();
        awvalid = 0;
        chk("mid_aw_held", 512'(awready), 512'(1'b0));
        #1 rst = 1;
        #1;
        exp_regs = RST;
        chk("mid_rst_outs", 512'({awready, wready, arready, bvalid, rvalid, bresp, rresp, wr_pulse, rdata}), 512'(0));
        chk("mid_rst_regs", regs_o, exp_regs);
        tick();
        rst = 0;
        tick();
        chk("mid_rel_ready", 512'({awready, wready, arready}), 512'(3'b111));
        wdata = 32'hBAD0BAD0; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        repeat (4) tick();
        chk("mid_no_commit", 512'(bvalid), 512'(1'b0));
        chk("mid_no_write", regs_o, exp_regs);
        awaddr = 32'h14; awvalid = 1; bready = 1;
        tick();
        awvalid = 0;
        for (int i = 0; i < 20 && !bvalid; i++) tick();
        exp_regs[160 +: 32] = 32'hBAD0BAD0;
        chk("mid_next_resp", 512'({bvalid, bresp}), 512'(3'b100));
        chk("mid_next_regs", regs_o, exp_regs);
        tick();
        bready = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
